// File: rtl/usr_nibble_deframer.sv
// usr_nibble_deframer
//
// Hunts a serial bit stream for a 4-bit sync word. Once the sync word is
// found, it assembles PAYLOAD_NIBBLES nibbles, MSB first, and queues each
// one in a small FIFO that drains over a valid/ready interface.
//
// Build option: define DEFRAMER_PARITY_EN to expect one odd-parity bit after
// every payload nibble. A nibble that fails the parity check is discarded and
// the frame is aborted.
//
// Parameters
//   SYNC_WORD        sync pattern; the oldest received bit is the MSB
//   PAYLOAD_NIBBLES  nibbles per frame, 1..15
//   FIFO_DEPTH       output FIFO entries, power of two, 2..16
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   ena        global enable; 0 freezes all state
//   bit_in     serial data bit
//   bit_valid  bit_in is accepted when ena=1
//   nib_data   FIFO head nibble (first received bit in bit 3)
//   nib_last   FIFO head is the final nibble of its frame
//   nib_valid  FIFO not empty
//   nib_ready  consumer accepts the head
//   frame_err  one-cycle pulse when a frame is aborted
//   overflow   sticky; a nibble was dropped because the FIFO was full
//   busy       FSM is not hunting
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_HUNT    | searching for SYNC_WORD in the incoming bits
// ST_PAYLOAD | shifting payload bits into the nibble assembler
// ST_PARITY  | waiting for the parity bit (parity builds only)
module usr_nibble_deframer #(
    parameter logic [3:0] SYNC_WORD       = 4'b1011,
    parameter int         PAYLOAD_NIBBLES = 4,
    parameter int         FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [3:0] nib_data,
    output logic       nib_last,
    output logic       nib_valid,
    input  logic       nib_ready,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = 1;
    localparam logic [AW:0]    CNT_ONE  = 1;
    localparam logic [3:0]     LAST_NIB = 4'(PAYLOAD_NIBBLES - 1);

`ifdef DEFRAMER_PARITY_EN
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_PARITY  = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;
`endif

    state_t state_q, state_d;

    // Only the three most recent bits need storing. The fourth bit of the
    // compare window is always the bit being accepted on the current edge.
    logic [2:0]    win_q, win_d;
    logic [3:0]    asm_q, asm_d;
    logic [1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    nib_cnt_q, nib_cnt_d;
    logic          overflow_q;
    logic          frame_err_q;

    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [3:0]    asm_shift;
    logic          push_req;
    logic [3:0]    push_data;
    logic          push_last;
    logic          drop;
    logic          abort;
    logic          wr_en;

    assign accept     = ena & bit_valid;
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign pop        = ena & ~fifo_empty & nib_ready;
    assign asm_shift  = {asm_q[2:0], bit_in};
    assign push_last  = (nib_cnt_q == LAST_NIB);
    assign wr_en      = push_req & ~drop;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        asm_d     = asm_q;
        bit_cnt_d = bit_cnt_q;
        nib_cnt_d = nib_cnt_q;
        push_req  = 1'b0;
        push_data = asm_shift;
        drop      = 1'b0;
        abort     = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (accept) begin
                    win_d = {win_q[1:0], bit_in};
                    if ({win_q, bit_in} == SYNC_WORD) begin
                        state_d   = ST_PAYLOAD;
                        bit_cnt_d = 2'd0;
                        nib_cnt_d = 4'd0;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    asm_d     = asm_shift;
                    bit_cnt_d = bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'd3) begin
`ifdef DEFRAMER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        push_req  = 1'b1;
                        push_data = asm_shift;
`endif
                    end
                end
            end
`ifdef DEFRAMER_PARITY_EN
            ST_PARITY: begin
                if (accept) begin
                    // Odd parity: nibble plus parity bit must hold an odd count of ones.
                    if (^{asm_q, bit_in}) begin
                        push_req  = 1'b1;
                        push_data = asm_q;
                    end else begin
                        abort   = 1'b1;
                        state_d = ST_HUNT;
                        win_d   = 3'd0;
                    end
                end
            end
`endif
            default: state_d = ST_HUNT;
        endcase

        // A pop on the same edge frees a slot, so a full FIFO can still take the push.
        if (push_req) begin
            if (fifo_full && !pop) begin
                drop    = 1'b1;
                abort   = 1'b1;
                state_d = ST_HUNT;
                win_d   = 3'd0;
            end else if (push_last) begin
                state_d = ST_HUNT;
                win_d   = 3'd0;
            end else begin
                nib_cnt_d = nib_cnt_q + 4'd1;
                state_d   = ST_PAYLOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            win_q       <= 3'd0;
            asm_q       <= 4'd0;
            bit_cnt_q   <= 2'd0;
            nib_cnt_q   <= 4'd0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            frame_err_q <= abort;
            if (ena) begin
                state_q   <= state_d;
                win_q     <= win_d;
                asm_q     <= asm_d;
                bit_cnt_q <= bit_cnt_d;
                nib_cnt_q <= nib_cnt_d;
                if (drop) begin
                    overflow_q <= 1'b1;
                end
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                case ({wr_en, pop})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && ena && wr_en) begin
            mem[wr_ptr_q] <= {push_last, push_data};
        end
    end

    assign nib_valid = ~fifo_empty;
    assign nib_data  = fifo_empty ? 4'd0 : mem[rd_ptr_q][3:0];
    assign nib_last  = fifo_empty ? 1'b0 : mem[rd_ptr_q][4];
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != ST_HUNT);

endmodule

// File: tb/tb_usr_nibble_deframer.sv
// Directed bench for usr_nibble_deframer. Two instances share the same input
// stream. dut_a uses two nibbles per frame and a depth-4 FIFO. dut_b uses
// three nibbles per frame and a depth-2 FIFO, so it can be driven into
// backpressure and overflow. Each scenario checks only the instance it targets.
module tb_usr_nibble_deframer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena, bit_in, bit_valid, nib_ready;

    logic [3:0] a_data;
    logic       a_last, a_valid, a_ferr, a_ovf, a_busy;
    logic [3:0] b_data;
    logic       b_last, b_valid, b_ferr, b_ovf, b_busy;

    int n_checks = 0;
    int n_errors = 0;

    usr_nibble_deframer #(
        .SYNC_WORD(4'b1011), .PAYLOAD_NIBBLES(2), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bit_in(bit_in), .bit_valid(bit_valid),
        .nib_data(a_data), .nib_last(a_last), .nib_valid(a_valid), .nib_ready(nib_ready),
        .frame_err(a_ferr), .overflow(a_ovf), .busy(a_busy)
    );

    usr_nibble_deframer #(
        .SYNC_WORD(4'b1011), .PAYLOAD_NIBBLES(3), .FIFO_DEPTH(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bit_in(bit_in), .bit_valid(bit_valid),
        .nib_data(b_data), .nib_last(b_last), .nib_valid(b_valid), .nib_ready(nib_ready),
        .frame_err(b_ferr), .overflow(b_ovf), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    endtask

    task automatic send_nib(input logic [3:0] n);
        for (int i = 3; i >= 0; i--) send_bit(n[i]);
`ifdef DEFRAMER_PARITY_EN
        send_bit(~^n);
`endif
    endtask

    // Same as send_nib, except that nib_ready is raised for the final edge
    // only, which is the edge that completes the nibble.
    task automatic send_nib_pop_last(input logic [3:0] n);
`ifdef DEFRAMER_PARITY_EN
        for (int i = 3; i >= 0; i--) send_bit(n[i]);
        nib_ready = 1'b1;
        send_bit(~^n);
`else
        for (int i = 3; i >= 1; i--) send_bit(n[i]);
        nib_ready = 1'b1;
        send_bit(n[0]);
`endif
        nib_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; nib_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        check("rst_valid", a_valid, 1'b0);
        check("rst_data",  a_data,  4'h0);
        check("rst_last",  a_last,  1'b0);
        check("rst_ferr",  a_ferr,  1'b0);
        check("rst_ovf",   a_ovf,   1'b0);
        check("rst_busy",  a_busy,  1'b0);

        // Basic frame on dut_a
        nib_ready = 1'b1;
        send_bit(0); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
        check("basic_busy_pre", a_busy, 1'b0);
        send_bit(1);
        check("basic_busy_sync", a_busy, 1'b1);
        send_nib(4'h6);
        check("basic_n0_valid", a_valid, 1'b1);
        check("basic_n0_data",  a_data,  4'h6);
        check("basic_n0_last",  a_last,  1'b0);
        send_nib(4'hC);
        check("basic_n1_data",  a_data,  4'hC);
        check("basic_n1_last",  a_last,  1'b1);
        check("basic_busy_end", a_busy,  1'b0);
        tick();
        check("basic_drained",  a_valid, 1'b0);
        nib_ready = 1'b0;
        do_reset();

`ifdef DEFRAMER_PARITY_EN
        // Parity pass, then fail, on dut_a
        send_sync();
        send_bit(0); send_bit(1); send_bit(1); send_bit(0); send_bit(1);
        check("par_ok_valid", a_valid, 1'b1);
        check("par_ok_data",  a_data,  4'h6);
        check("par_ok_busy",  a_busy,  1'b1);
        send_bit(1); send_bit(1); send_bit(1); send_bit(0); send_bit(1);
        check("par_bad_ferr", a_ferr,  1'b1);
        check("par_bad_busy", a_busy,  1'b0);
        check("par_bad_keep", a_data,  4'h6);
        tick();
        check("par_ferr_pulse", a_ferr, 1'b0);
        do_reset();
`endif

        // Backpressure and overflow on dut_b
        send_sync();
        send_nib(4'h1);
        check("ovf_n0_valid", b_valid, 1'b1);
        check("ovf_n0_data",  b_data,  4'h1);
        check("ovf_n0_last",  b_last,  1'b0);
        send_nib(4'h2);
        send_nib(4'h3);
        check("ovf_flag",     b_ovf,   1'b1);
        check("ovf_ferr",     b_ferr,  1'b1);
        check("ovf_busy",     b_busy,  1'b0);
        check("ovf_head",     b_data,  4'h1);
        tick();
        check("ovf_ferr_pulse", b_ferr, 1'b0);
        nib_ready = 1'b1;
        tick();
        check("ovf_pop1_data", b_data,  4'h2);
        check("ovf_pop1_last", b_last,  1'b0);
        tick();
        check("ovf_empty",     b_valid, 1'b0);
        nib_ready = 1'b0;
        check("ovf_sticky",    b_ovf,   1'b1);
        do_reset();
        check("ovf_cleared",   b_ovf,   1'b0);

        // Full FIFO with a simultaneous pop on dut_b
        send_sync();
        send_nib(4'h4);
        send_nib(4'h5);
        check("fullpop_head0", b_data, 4'h4);
        send_nib_pop_last(4'h6);
        check("fullpop_ovf",   b_ovf,   1'b0);
        check("fullpop_ferr",  b_ferr,  1'b0);
        check("fullpop_valid", b_valid, 1'b1);
        check("fullpop_head1", b_data,  4'h5);
        check("fullpop_busy",  b_busy,  1'b0);
        nib_ready = 1'b1;
        tick();
        check("fullpop_head2", b_data,  4'h6);
        check("fullpop_last",  b_last,  1'b1);
        tick();
        check("fullpop_empty", b_valid, 1'b0);
        nib_ready = 1'b0;

        // Reset mid-frame on dut_b
        do_reset();
        send_sync();
        send_nib(4'h7);
        send_bit(1); send_bit(0);
        check("mid_queued", b_valid, 1'b1);
        check("mid_busy",   b_busy,  1'b1);
        do_reset();
        check("mid_rst_valid", b_valid, 1'b0);
        check("mid_rst_busy",  b_busy,  1'b0);
        nib_ready = 1'b1;
        send_sync();
        send_nib(4'h7);
        check("mid_re_n0", b_data, 4'h7);
        check("mid_re_l0", b_last, 1'b0);
        send_nib(4'h8);
        check("mid_re_n1", b_data, 4'h8);
        send_nib(4'h9);
        check("mid_re_n2", b_data, 4'h9);
        check("mid_re_l2", b_last, 1'b1);
        tick();
        check("mid_re_empty", b_valid, 1'b0);
        nib_ready = 1'b0;

        // Enable gating on dut_b
        do_reset();
        ena = 1'b0;
        send_sync();
        check("ena_no_sync_b", b_busy, 1'b0);
        check("ena_no_sync_a", a_busy, 1'b0);
        ena = 1'b1;
        send_sync();
        check("ena_sync", b_busy, 1'b1);
        send_nib(4'hA);
        check("ena_q_valid", b_valid, 1'b1);
        check("ena_q_data",  b_data,  4'hA);
        ena = 1'b0;
        nib_ready = 1'b1;
        tick(); tick();
        check("ena_hold_valid", b_valid, 1'b1);
        check("ena_hold_data",  b_data,  4'hA);
        ena = 1'b1;
        tick();
        check("ena_popped", b_valid, 1'b0);
        nib_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/usr_nibble_deframer.md
# usr_nibble_deframer

Serial-to-nibble deframer that sits directly downstream of the 4-bit universal shift register tile. It hunts a serial bit stream for a 4-bit sync word, then assembles a fixed number of MSB-first payload nibbles. Each nibble is pushed into a small FIFO and delivered over a valid/ready interface. It absorbs the shift register's serial output (MSB tap) and presents framed data to the consuming logic.

## Interface
- SYNC_WORD, 4'b1011: sync pattern, compared against the last 4 accepted bits; the oldest bit is the MSB of the compare window.
- PAYLOAD_NIBBLES, 4: nibbles per frame, legal range 1..15.
- FIFO_DEPTH, 4: output FIFO entries, power of two, 2..16.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable; 0 freezes all state.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is accepted on this edge when ena=1.
- nib_data  out  4  FIFO head nibble; the first bit received is bit 3.
- nib_last  out  1  FIFO head is the final nibble of its frame.
- nib_valid  out  1  FIFO not empty.
- nib_ready  in  1  consumer accepts the head.
- frame_err  out  1  one-cycle pulse: a frame was aborted.
- overflow  out  1  sticky; a nibble was dropped because the FIFO was full.
- busy  out  1  state is not HUNT.

## Operation
- An accepted bit requires ena=1 and bit_valid=1. A pop requires ena=1, nib_valid=1 and nib_ready=1.
- **HUNT:**
  - Each accepted bit updates the window: win <= {win[2:0], bit_in}.
  - If {win[2:0], bit_in} == SYNC_WORD, go to PAYLOAD with bit_cnt=0 and nib_cnt=0.
- **PAYLOAD:**
  - Accepted bits shift into the assembler MSB-first: asm <= {asm[2:0], bit_in}.
  - On the 4th bit the nibble is complete. Without parity it is pushed immediately. With parity the block goes to PARITY.
- **PARITY** (only when DEFRAMER_PARITY_EN is defined):
  - The next accepted bit is the parity bit. The check is odd parity: the nibble plus the parity bit must contain an odd number of 1s.
  - Pass: push the nibble and return to PAYLOAD, or to HUNT after the last nibble.
  - Fail: discard the nibble, pulse frame_err, go to HUNT.
- **Push:**
  - nib_last = (nib_cnt == PAYLOAD_NIBBLES-1).
  - After the last nibble, go to HUNT and clear win to 0, so the next sync needs 4 fresh bits.
  - Otherwise increment nib_cnt.
- **Push while the FIFO is full and no pop in the same cycle:**
  - Drop the nibble and set overflow.
  - Pulse frame_err and go to HUNT with win cleared.
- **Push while full with a pop in the same cycle:** accepted, and the occupancy stays the same.
- Nibbles already in the FIFO are never retracted by a later abort.
- Sync detection is disabled outside HUNT; a payload that contains SYNC_WORD is ordinary data.

## Timing
- Reset values:
  - State HUNT; win, asm, bit_cnt and nib_cnt all 0; FIFO empty.
  - nib_data=0, nib_last=0, nib_valid=0, frame_err=0, overflow=0, busy=0.
- A reset asserted mid-frame discards the partial nibble and all FIFO contents on that edge.
- Sync-to-PAYLOAD: busy rises on the edge that accepts the 4th sync bit.
- Push latency: the nibble-completing edge (or parity edge) writes the FIFO, and nib_valid=1 is visible after that same edge.
- Minimum bit-to-output latency is 1 cycle. There is no combinational path from bit_in to any output.
- nib_data and nib_last are stable while nib_valid=1 and nib_ready=0.
- frame_err is high for exactly one cycle after the aborting edge.
- overflow clears only on reset.
- With ena=0 the FIFO, FSM and outputs hold; a high nib_ready is ignored.

## Configuration
- DEFRAMER_PARITY_EN defined:
  - Each payload nibble is followed by one odd-parity bit.
  - The PARITY state exists.
  - A frame is 4 + 5*PAYLOAD_NIBBLES bits.
- Not defined:
  - No parity bit; the PARITY state is absent.
  - frame_err fires only on overflow.
  - A frame is 4 + 4*PAYLOAD_NIBBLES bits.

## Test plan
All scenarios use SYNC_WORD=1011.

- **Basic frame:** no parity, PAYLOAD_NIBBLES=2, nib_ready=1, bits 0,0,1,0,1,1, 0,1,1,0, 1,1,0,0.
  - busy rises after the 6th bit.
  - Outputs 0x6 (last=0), then 0xC (last=1).
  - busy returns to 0.
- **Parity pass and fail:** parity enabled.
  - Payload 0,1,1,0 with parity bit 1 yields 0x6.
  - A following nibble 1,1,1,0 with parity bit 1 is discarded, frame_err pulses once, and the block is in HUNT.
- **Backpressure and overflow:** FIFO_DEPTH=2, PAYLOAD_NIBBLES=3, nib_ready=0, payload 0x1, 0x2, 0x3.
  - The FIFO holds 0x1 and 0x2; 0x3 is dropped.
  - overflow=1 and frame_err pulses.
  - Popping then yields 0x1, then 0x2, and nib_valid=0.
- **Full with simultaneous pop:** FIFO full and nib_ready=1 on the edge that completes a nibble.
  - The nibble is accepted, overflow stays 0, and occupancy is unchanged.
- **Reset mid-frame:** rst_n=0 for one cycle after 2 payload bits with one nibble queued.
  - nib_valid=0 and busy=0.
  - Resending the full frame produces the correct nibbles.
- **Enable gating:** ena=0 while bit_valid=1 with bits 1,0,1,1.
  - No sync is detected and busy stays 0.
  - A queued nibble is not popped even though nib_ready=1.
